race_timer_scoreboard: RTL and testbench

- Downstream of the drag-race state machine.
- Times each run in centiseconds, from launch until the car reaches the win speed or crashes.
- Freezes the finishing time and keeps the best winning time across games until hard reset.
- Outputs packed BCD digits straight to the 7-segment display mux.

---
 rtl/race_timer_scoreboard.sv | 123 ++++++++++++
 tb/tb_race_timer_scoreboard.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/race_timer_scoreboard.sv
// Drag-race run timer: counts centiseconds in packed BCD from launch to win/crash/timeout
// and keeps the best winning time until hard reset.
module race_timer_scoreboard #(
    parameter int TICK_DIV  = 500000,
    parameter int WIN_SPEED = 200
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        NewGame,
    input  logic        Launch,
    input  logic        Crash,
    input  logic [8:0]  Speed,
    output logic [15:0] TimeBCD,
    output logic [15:0] BestBCD,
    output logic        Running,
    output logic        Finished,
    output logic        Dnf,
    output logic        BestValid,
    output logic        NewRecord
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [8:0]    WIN_THR    = 9'(WIN_SPEED);
    localparam logic [15:0]   TIME_MAX   = 16'h9999;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUNNING,
        S_FINISHED,
        S_DNF
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [15:0]   time_bcd;
    logic [15:0]   best_bcd;
    logic          best_valid;
    logic          new_record;
    logic          tick;

    // Four-digit BCD increment with a ripple carry between digits.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (r[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            presc      <= '0;
            time_bcd   <= '0;
            best_bcd   <= '0;
            best_valid <= 1'b0;
            new_record <= 1'b0;
        end else if (NewGame) begin
            state      <= S_IDLE;
            presc      <= '0;
            time_bcd   <= '0;
            new_record <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Launch) begin
                        state    <= S_RUNNING;
                        presc    <= '0;
                        time_bcd <= '0;
                    end
                end
                S_RUNNING: begin
                    if (Crash) begin
                        state <= S_DNF;
                    end else if (Speed >= WIN_THR) begin
                        state <= S_FINISHED;
                        // Packed BCD orders the same as unsigned binary; ties are not records.
                        if (!best_valid || (time_bcd < best_bcd)) begin
                            best_bcd   <= time_bcd;
                            best_valid <= 1'b1;
                            new_record <= 1'b1;
                        end else begin
                            new_record <= 1'b0;
                        end
                    end else begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (time_bcd == TIME_MAX) begin
                                state <= S_DNF;
                            end else begin
                                time_bcd <= bcd_inc(time_bcd);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign TimeBCD   = time_bcd;
    assign BestBCD   = best_bcd;
    assign Running   = (state == S_RUNNING);
    assign Finished  = (state == S_FINISHED);
    assign Dnf       = (state == S_DNF);
    assign BestValid = best_valid;
    assign NewRecord = new_record;

endmodule

// File: tb/tb_race_timer_scoreboard.sv
// Bench for race_timer_scoreboard: directed scenarios plus random games against an
// elapsed-cycle arithmetic model of the run timer.
module tb_race_timer_scoreboard;

    localparam int TD = 4;

    logic        Clock = 1'b0;
    logic        Reset, NewGame, Launch, Crash;
    logic [8:0]  Speed;
    logic [15:0] TimeBCD, BestBCD;
    logic        Running, Finished, Dnf, BestValid, NewRecord;

    int errors = 0;
    int checks = 0;

    // Model: 0 idle, 1 running, 2 finished, 3 dnf; times in plain centiseconds.
    int m_mode = 0;
    int m_time = 0;
    int m_best = 0;
    int m_elapsed = 0;
    bit m_bv = 0;
    bit m_nr = 0;

    race_timer_scoreboard #(.TICK_DIV(TD), .WIN_SPEED(200)) dut (
        .Clock(Clock), .Reset(Reset), .NewGame(NewGame), .Launch(Launch),
        .Crash(Crash), .Speed(Speed), .TimeBCD(TimeBCD), .BestBCD(BestBCD),
        .Running(Running), .Finished(Finished), .Dnf(Dnf),
        .BestValid(BestValid), .NewRecord(NewRecord)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (Reset) begin
            m_mode = 0; m_time = 0; m_best = 0; m_bv = 0; m_nr = 0; m_elapsed = 0;
        end else if (NewGame) begin
            m_mode = 0; m_time = 0; m_nr = 0; m_elapsed = 0;
        end else if (m_mode == 0) begin
            if (Launch) begin
                m_mode = 1; m_time = 0; m_elapsed = 0;
            end
        end else if (m_mode == 1) begin
            if (Crash) begin
                m_mode = 3;
            end else if (Speed >= 9'd200) begin
                m_mode = 2;
                m_nr = (!m_bv || m_time < m_best);
                if (m_nr) begin
                    m_best = m_time;
                    m_bv = 1;
                end
            end else begin
                m_elapsed++;
                if (m_elapsed / TD > 9999) m_mode = 3;
                else m_time = m_elapsed / TD;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clock);
        #1;
        chk("time", TimeBCD, to_bcd(m_time));
        chk("best", BestBCD, to_bcd(m_best));
        chk("running", 16'(Running), 16'(m_mode == 1));
        chk("finished", 16'(Finished), 16'(m_mode == 2));
        chk("dnf", 16'(Dnf), 16'(m_mode == 3));
        chk("bestvalid", 16'(BestValid), 16'(m_bv));
        chk("newrecord", 16'(NewRecord), 16'(m_nr));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            Speed = 9'($urandom_range(0, 199));
            Crash = 1'b0;
            cycle();
        end
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (m_time != target && m_mode == 1 && n < target * TD + 16) begin
            run_cycles(1);
            n++;
        end
        chk("reach_target", TimeBCD, to_bcd(target));
    endtask

    task automatic pulse_newgame();
        NewGame = 1'b1; cycle(); NewGame = 1'b0;
    endtask

    task automatic pulse_launch();
        Launch = 1'b1; cycle(); Launch = 1'b0;
    endtask

    task automatic win();
        Speed = 9'($urandom_range(200, 511)); cycle(); Speed = 9'd0;
    endtask

    initial begin
        Reset = 1'b1; NewGame = 1'b0; Launch = 1'b0; Crash = 1'b0; Speed = 9'd0;
        cycle();
        cycle();
        Reset = 1'b0;
        chk("rst_time", TimeBCD, 16'h0000);
        chk("rst_flags", {11'd0, Running, Finished, Dnf, BestValid, NewRecord}, 16'h0000);

        // Scenario 1: first tick lands TICK_DIV cycles after Running rises
        pulse_launch();
        chk("s1_running", 16'(Running), 16'h0001);
        run_cycles(TD - 1);
        chk("s1_pre_tick", TimeBCD, 16'h0000);
        run_cycles(1);
        chk("s1_first_tick", TimeBCD, 16'h0001);
        run_cycles(40 - TD);
        chk("s1_time40", TimeBCD, 16'h0010);

        // Scenario 2: first win sets the record
        run_until(123);
        win();
        chk("s2_finished", 16'(Finished), 16'h0001);
        chk("s2_time", TimeBCD, 16'h0123);
        chk("s2_best", BestBCD, 16'h0123);
        chk("s2_nr", {BestValid, NewRecord}, 2'b11);
        for (int i = 0; i < 20; i++) begin
            Speed = 9'($urandom_range(0, 511));
            cycle();
        end
        chk("s2_hold", TimeBCD, 16'h0123);

        // Scenario 3: slower, faster and tie runs
        pulse_newgame(); pulse_launch(); run_until(150); win();
        chk("s3_slow_best", BestBCD, 16'h0123);
        chk("s3_slow_nr", 16'(NewRecord), 16'h0000);
        pulse_newgame(); pulse_launch(); run_until(99); win();
        chk("s3_fast_best", BestBCD, 16'h0099);
        chk("s3_fast_nr", 16'(NewRecord), 16'h0001);
        pulse_newgame(); pulse_launch(); run_until(99); win();
        chk("s3_tie_nr", 16'(NewRecord), 16'h0000);

        // Scenario 4: crash beats a coincident win
        pulse_newgame(); pulse_launch(); run_until(40);
        Crash = 1'b1; Speed = 9'd250; cycle(); Crash = 1'b0; Speed = 9'd0;
        chk("s4_dnf", {14'd0, Dnf, Finished}, 16'h0002);
        chk("s4_time", TimeBCD, 16'h0040);
        chk("s4_best", BestBCD, 16'h0099);

        // Scenario 5: timeout at 99.99 without wrap
        pulse_newgame(); pulse_launch(); run_until(9998);
        run_cycles(2 * TD);
        chk("s5_dnf", 16'(Dnf), 16'h0001);
        chk("s5_time", TimeBCD, 16'h9999);
        run_cycles(TD * 2);
        chk("s5_hold", TimeBCD, 16'h9999);

        // Scenario 6: hard reset mid-run, reset with NewGame, Launch in FINISHED
        pulse_newgame(); pulse_launch(); run_until(200);
        Reset = 1'b1; cycle(); Reset = 1'b0;
        chk("s6_rst", {BestBCD[7:0], 3'd0, Running, Finished, Dnf, BestValid, NewRecord}, 16'h0000);
        chk("s6_rst_time", TimeBCD, 16'h0000);
        Reset = 1'b1; NewGame = 1'b1; cycle(); Reset = 1'b0; NewGame = 1'b0;
        chk("s6_rst_ng", {11'd0, Running, Finished, Dnf, BestValid, NewRecord}, 16'h0000);
        pulse_launch(); run_until(5); win();
        pulse_launch();
        chk("s6_launch_fin", {14'd0, Running, Finished}, 16'h0001);

        // Random games
        for (int g = 0; g < 30; g++) begin
            if ($urandom_range(0, 9) == 0) begin
                Reset = 1'b1; cycle(); Reset = 1'b0;
            end else if ($urandom_range(0, 4) != 0) begin
                pulse_newgame();
            end
            Crash = 1'b1; cycle(); Crash = 1'b0;
            pulse_launch();
            for (int c = 0; c < 400 && m_mode == 1; c++) begin
                Speed = ($urandom_range(0, 29) == 0) ? 9'($urandom_range(200, 511))
                                                     : 9'($urandom_range(0, 199));
                Crash = ($urandom_range(0, 59) == 0);
                cycle();
            end
            for (int c = 0; c < 5; c++) begin
                Speed  = 9'($urandom_range(0, 511));
                Crash  = 1'($urandom_range(0, 1));
                Launch = 1'($urandom_range(0, 1));
                cycle();
            end
            Crash = 1'b0; Launch = 1'b0; Speed = 9'd0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
